display_scan_ctrl: RTL and testbench
====================================

Name: display_scan_ctrl

Overview:
- Sequencing controller for the 8-digit multiplexed seven-segment display path (digit counter → nibble mux → hex-to-segment → anode decoder).
- Replaces the free-running counter with timed digit slots, a dead-time between digits, brightness PWM, leading-zero and per-digit blanking, and a tear-free load handshake.
- Outputs `nibble` feeds the existing hex-to-segment block; `anodes` drives the board directly.

Parameters:
- SLOT_CYC, 100000, clock cycles per digit slot (≥ BLANK_CYC+8).
- BLANK_CYC, 64, cycles at slot start with all anodes off (ghosting dead-time).
- DIGITS, 8, digit count; fixed at 8 for this board (digit_sel 3 bits).

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- value_in  in  32  new display value, nibble i shown on digit i.
- load_valid  in  1  value_in valid; accepted when load_valid && load_ready.
- load_ready  out  1  controller can accept a new value.
- digit_en  in  8  per-digit enable mask (1 = digit may light).
- lz_blank  in  1  1 = suppress leading zeros.
- brightness  in  3  on-time level, 0 = 1/8 … 7 = 8/8 of lit window.
- digit_sel  out  3  current digit index.
- nibble  out  4  active_value nibble for digit_sel.
- anodes  out  8  active-low anode drive, 8'hFF = all off.
- frame_done  out  1  one-cycle pulse at end of digit 7 slot.

Behaviour:
- Reset (async assert, sync release): anodes=8'hFF, digit_sel=0, nibble=0, frame_done=0, load_ready=1, active_value=0, shadow=0, pending=0, phase=0, state=S_BLANK.
- `phase` counts 0..SLOT_CYC-1 each slot. At phase == SLOT_CYC-1:
  - phase wraps to 0.
  - digit_sel increments, wrapping 7→0.
  - state goes to S_BLANK.
- Lit window: W = SLOT_CYC-BLANK_CYC. On-time T = (W*(brightness+1))>>3. Use a width-safe product, computed from brightness sampled at the slot start; brightness changes mid-slot are ignored.
- FSM:
  - S_BLANK: anodes=FF. At phase==BLANK_CYC-1 go to S_ON.
  - S_ON: anodes = ~(1<<digit_sel) if lit, else FF. After T cycles go to S_DARK, except when T==W, where it stays in S_ON until wrap.
  - S_DARK: anodes=FF until wrap.
- lit(i) = digit_en[i] && !lz(i).
  - lz(i)=1 iff lz_blank && i≠0 && active_value nibbles i..7 are all zero.
  - Digit 0 always shows when enabled.
- nibble = active_value[4*digit_sel +: 4], combinational from registered digit_sel; valid during blank too.
- Load handshake:
  - load_ready = !pending.
  - On accept, shadow ← value_in and pending ← 1.
  - At the frame boundary (wrap 7→0): if pending, active_value ← shadow and pending ← 0, so load_ready is 1 from the next cycle.
  - A value accepted in the boundary cycle itself applies at the next frame boundary, never mid-frame.
- frame_done is high exactly in the cycle phase==SLOT_CYC-1 && digit_sel==7. It coincides with the active_value update.
- Reset mid-slot: all outputs go to reset values immediately; anodes off.
- No combinational path from load_valid to load_ready.

Decomposition:
- Package disp_pkg:
  - scan_state_t enum {S_BLANK,S_ON,S_DARK}.
  - NUM_DIGITS=8.
  - ANODES_OFF=8'hFF.
- Sub-module slot_timer: phase counter with wrap pulse and blank_end pulse, parameterised by SLOT_CYC/BLANK_CYC.
- FSM, load logic, blanking and anode generation live in display_scan_ctrl.

Test Plan (SLOT_CYC=16, BLANK_CYC=2, so W=14):
- Reset release, brightness=7, digit_en=FF, value loaded 32'h1234_5678:
  - after the first frame, the digit 0 slot shows anodes=FF for 2 cycles, then 8'hFE for 14 cycles with nibble=8.
  - digit 7 gives 8'h7F with nibble=1.
  - frame_done pulses every 128 cycles.
- brightness=3: T=(14*4)>>3=7, so each slot is 2 off, 7 on, 7 off. brightness=0: T=1.
- lz_blank=1, value 32'h0000_0A00: digits 3–7 anodes stay FF. Digits 0–2 light with nibbles 0,0,A. Value 0: only digit 0 lights, showing 0.
- Load 32'hAAAA_AAAA mid-frame (digit 3): load_ready drops the next cycle, displayed nibbles stay old through digit 7, and the new value appears at digit 0 with load_ready=1. A second load_valid while pending is not accepted.
- digit_en=8'b0000_0101: only anodes FE and FB ever assert, and no two bits are ever low simultaneously.
- Assert reset (0) during S_ON of digit 5: anodes=FF, digit_sel=0, load_ready=1 asynchronously. After release, scanning restarts at digit 0 phase 0 with active_value=0.

Source files
------------

// File: rtl/disp_pkg.sv
// Shared types and constants for the multiplexed seven-segment scan path.
package disp_pkg;

  // Per-slot sequencing: dead-time, lit window, then dark until the slot ends.
  typedef enum logic [1:0] {
    S_BLANK = 2'd0,
    S_ON    = 2'd1,
    S_DARK  = 2'd2
  } scan_state_t;

  localparam int         NUM_DIGITS = 8;
  localparam logic [7:0] ANODES_OFF = 8'hFF;

  // Active-low one-cold anode pattern for a single digit.
  function automatic logic [7:0] digit_anode(input logic [2:0] sel);
    logic [7:0] oneHot;
    oneHot = 8'b0000_0001 << sel;
    return ~oneHot;
  endfunction

endpackage

// File: rtl/slot_timer.sv
// Digit-slot phase counter: counts 0..SLOT_CYC-1 and flags the slot's last
// cycle (wrap) and the last cycle of the ghosting dead-time (blank end).
module slot_timer #(
  parameter  int SLOT_CYC  = 100000,
  parameter  int BLANK_CYC = 64,
  localparam int PW        = $clog2(SLOT_CYC)
) (
  input  logic          clock,
  input  logic          reset,
  output logic [PW-1:0] phase_o,
  output logic          wrap_o,
  output logic          blankEnd_o
);

  localparam logic [PW-1:0] LAST_PHASE  = PW'(SLOT_CYC - 1);
  localparam logic [PW-1:0] BLANK_LAST  = PW'(BLANK_CYC - 1);

  logic [PW-1:0] phase_q;
  logic [PW-1:0] phase_d;

  assign phase_o    = phase_q;
  assign wrap_o     = (phase_q == LAST_PHASE);
  assign blankEnd_o = (phase_q == BLANK_LAST);

  // Next phase: advance every cycle, returning to zero after the last cycle.
  always_comb begin
    phase_d = phase_q + 1'b1;
    if (wrap_o) begin
      phase_d = '0;
    end
  end

  // Phase register, cleared asynchronously by the active-low reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      phase_q <= '0;
    end else begin
      phase_q <= phase_d;
    end
  end

endmodule

// File: rtl/display_scan_ctrl.sv
// Scan sequencer for the 8-digit multiplexed display: timed digit slots with
// dead-time, brightness PWM, leading-zero / per-digit blanking and a load
// handshake that only swaps the displayed value at a frame boundary.
module display_scan_ctrl
  import disp_pkg::*;
#(
  parameter int SLOT_CYC  = 100000,
  parameter int BLANK_CYC = 64,
  parameter int DIGITS    = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] value_in,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [7:0]  digit_en,
  input  logic        lz_blank,
  input  logic [2:0]  brightness,
  output logic [2:0]  digit_sel,
  output logic [3:0]  nibble,
  output logic [7:0]  anodes,
  output logic        frame_done
);

  localparam int PW  = $clog2(SLOT_CYC);
  localparam int W   = SLOT_CYC - BLANK_CYC;
  localparam int PRW = PW + 4;

  localparam logic [2:0]    LAST_DIGIT = 3'(DIGITS - 1);
  localparam logic [PW-1:0] ON_BASE    = PW'(BLANK_CYC - 1);
  localparam logic [PRW-1:0] W_WIDE    = PRW'(W);

  logic [PW-1:0] phase;
  logic          wrap;
  logic          blankEnd;
  logic          slotStart;

  scan_state_t   state_q, state_d;
  logic [2:0]    digitSel_q, digitSel_d;
  logic [31:0]   active_q, active_d;
  logic [31:0]   shadow_q, shadow_d;
  logic          pending_q, pending_d;
  logic [PW-1:0] onTime_q, onTime_d;

  logic [PRW-1:0] onProduct;
  logic [PW-1:0]  onEndPhase;
  logic           accept;
  logic [7:0]     litVec;
  logic           upperZero;

  slot_timer #(
    .SLOT_CYC  (SLOT_CYC),
    .BLANK_CYC (BLANK_CYC)
  ) u_slot_timer (
    .clock      (clock),
    .reset      (reset),
    .phase_o    (phase),
    .wrap_o     (wrap),
    .blankEnd_o (blankEnd)
  );

  assign slotStart  = (phase == '0);
  assign frame_done = wrap && (digitSel_q == LAST_DIGIT);
  assign load_ready = !pending_q;
  assign accept     = load_valid && !pending_q;
  assign digit_sel  = digitSel_q;
  assign nibble     = active_q[{digitSel_q, 2'b00} +: 4];

  // On-time for the coming slot: W*(brightness+1)/8, held for the whole slot.
  always_comb begin
    onProduct = W_WIDE * PRW'({1'b0, brightness} + 4'd1);
    onTime_d  = onTime_q;
    if (slotStart) begin
      onTime_d = PW'(onProduct >> 3);
    end
    onEndPhase = ON_BASE + onTime_q;
  end

  // Slot state: dead-time, lit for the on-time, dark until the slot wraps.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_BLANK: begin
        if (blankEnd) begin
          state_d = S_ON;
        end
      end
      S_ON: begin
        if (phase == onEndPhase) begin
          state_d = S_DARK;
        end
      end
      S_DARK: begin
        state_d = S_DARK;
      end
      default: begin
        state_d = S_BLANK;
      end
    endcase
    if (wrap) begin
      state_d = S_BLANK;
    end
  end

  // Digit index advances once per slot and cycles through all digits.
  always_comb begin
    digitSel_d = digitSel_q;
    if (wrap) begin
      if (digitSel_q == LAST_DIGIT) begin
        digitSel_d = '0;
      end else begin
        digitSel_d = digitSel_q + 3'd1;
      end
    end
  end

  // Load handshake: capture into the shadow, commit only at a frame boundary.
  always_comb begin
    shadow_d  = shadow_q;
    pending_d = pending_q;
    active_d  = active_q;
    if (frame_done && pending_q) begin
      active_d  = shadow_q;
      pending_d = 1'b0;
    end else if (accept) begin
      shadow_d  = value_in;
      pending_d = 1'b1;
    end
  end

  // Per-digit light permission: enabled and not a suppressed leading zero.
  always_comb begin
    upperZero = 1'b1;
    litVec    = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      upperZero = upperZero && (active_q[4*i +: 4] == 4'h0);
      litVec[i] = digit_en[i] && !(lz_blank && (i != 0) && upperZero);
    end
  end

  // Anode drive: only the selected digit, only in the lit window.
  always_comb begin
    anodes = ANODES_OFF;
    if ((state_q == S_ON) && litVec[digitSel_q]) begin
      anodes = digit_anode(digitSel_q);
    end
  end

  // Controller state registers, cleared asynchronously by the active-low reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= S_BLANK;
      digitSel_q <= '0;
      active_q   <= '0;
      shadow_q   <= '0;
      pending_q  <= 1'b0;
      onTime_q   <= '0;
    end else begin
      state_q    <= state_d;
      digitSel_q <= digitSel_d;
      active_q   <= active_d;
      shadow_q   <= shadow_d;
      pending_q  <= pending_d;
      onTime_q   <= onTime_d;
    end
  end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl with 16-cycle slots and 2-cycle dead-time.
module tb_display_scan_ctrl;

  logic        clock;
  logic        reset;
  logic [31:0] value_in;
  logic        load_valid;
  logic        load_ready;
  logic [7:0]  digit_en;
  logic        lz_blank;
  logic [2:0]  brightness;
  logic [2:0]  digit_sel;
  logic [3:0]  nibble;
  logic [7:0]  anodes;
  logic        frame_done;

  int checks;
  int failures;
  int cyc;

  display_scan_ctrl #(
    .SLOT_CYC  (16),
    .BLANK_CYC (2),
    .DIGITS    (8)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .value_in   (value_in),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .digit_en   (digit_en),
    .lz_blank   (lz_blank),
    .brightness (brightness),
    .digit_sel  (digit_sel),
    .nibble     (nibble),
    .anodes     (anodes),
    .frame_done (frame_done)
  );

  // Free-running 10-time-unit clock.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Expected anodes: lit for t cycles after the 2-cycle dead-time if allowed.
  function automatic logic [7:0] exp_an(input int ph, input int d, input int t, input logic [7:0] lm);
    logic [7:0] oneHot;
    oneHot = 8'd1 << d;
    if (ph >= 2 && ph < 2 + t && lm[d]) return ~oneHot;
    return 8'hFF;
  endfunction

  function automatic logic [3:0] exp_nib(input logic [31:0] v, input int d);
    return v[4*d +: 4];
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int target);
    while (cyc < target) step();
  endtask

  task automatic do_release();
    @(posedge clock);
    #1;
    reset = 1'b1;
    cyc = 0;
  endtask

  task automatic test_reset();
    #1;
    checks++; if (anodes !== 8'hFF) begin failures++; $display("[TB] FAIL reset_anodes got=%h exp=ff", anodes); end
    checks++; if (digit_sel !== 3'd0) begin failures++; $display("[TB] FAIL reset_digit_sel got=%0d exp=0", digit_sel); end
    checks++; if (nibble !== 4'h0) begin failures++; $display("[TB] FAIL reset_nibble got=%h exp=0", nibble); end
    checks++; if (frame_done !== 1'b0) begin failures++; $display("[TB] FAIL reset_frame_done got=%b exp=0", frame_done); end
    checks++; if (load_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_load_ready got=%b exp=1", load_ready); end
  endtask

  task automatic test_full_brightness();
    logic [31:0] v;
    v = 32'h1234_5678;
    checks++; if (load_ready !== 1'b1) begin failures++; $display("[TB] FAIL full_ready_start got=%b exp=1", load_ready); end
    value_in = v;
    load_valid = 1'b1;
    step();
    load_valid = 1'b0;
    checks++; if (load_ready !== 1'b0) begin failures++; $display("[TB] FAIL full_ready_pending got=%b exp=0", load_ready); end
    run_to(127);
    checks++; if (frame_done !== 1'b1) begin failures++; $display("[TB] FAIL full_first_frame_done got=%b exp=1", frame_done); end
    checks++; if (nibble !== 4'h0) begin failures++; $display("[TB] FAIL full_old_nibble got=%h exp=0", nibble); end
    checks++; if (load_ready !== 1'b0) begin failures++; $display("[TB] FAIL full_ready_boundary got=%b exp=0", load_ready); end
    run_to(128);
    checks++; if (load_ready !== 1'b1) begin failures++; $display("[TB] FAIL full_ready_after got=%b exp=1", load_ready); end
    for (int c = 128; c < 256; c++) begin
      int ph;
      int d;
      run_to(c);
      ph = c % 16;
      d = (c / 16) % 8;
      checks++; if (anodes !== exp_an(ph, d, 14, 8'hFF)) begin failures++; $display("[TB] FAIL full_anodes cyc=%0d got=%h exp=%h", c, anodes, exp_an(ph, d, 14, 8'hFF)); end
      checks++; if (nibble !== exp_nib(v, d)) begin failures++; $display("[TB] FAIL full_nibble cyc=%0d got=%h exp=%h", c, nibble, exp_nib(v, d)); end
      checks++; if (digit_sel !== 3'(d)) begin failures++; $display("[TB] FAIL full_digit_sel cyc=%0d got=%0d exp=%0d", c, digit_sel, d); end
      checks++; if (frame_done !== (ph == 15 && d == 7)) begin failures++; $display("[TB] FAIL full_frame_done cyc=%0d got=%b exp=%b", c, frame_done, (ph == 15 && d == 7)); end
    end
    run_to(256);
  endtask

  task automatic test_brightness();
    brightness = 3'd3;
    for (int c = 256; c < 384; c++) begin
      int ph;
      int d;
      run_to(c);
      ph = c % 16;
      d = (c / 16) % 8;
      checks++; if (anodes !== exp_an(ph, d, 7, 8'hFF)) begin failures++; $display("[TB] FAIL bright3_anodes cyc=%0d got=%h exp=%h", c, anodes, exp_an(ph, d, 7, 8'hFF)); end
      if (ph == 4) brightness = 3'd7;
      if (ph == 15) brightness = 3'd3;
    end
    run_to(384);
    brightness = 3'd0;
    for (int c = 384; c < 512; c++) begin
      int ph;
      int d;
      run_to(c);
      ph = c % 16;
      d = (c / 16) % 8;
      checks++; if (anodes !== exp_an(ph, d, 1, 8'hFF)) begin failures++; $display("[TB] FAIL bright0_anodes cyc=%0d got=%h exp=%h", c, anodes, exp_an(ph, d, 1, 8'hFF)); end
      if (ph == 2) brightness = 3'd7;
      if (ph == 15) brightness = 3'd0;
    end
    run_to(512);
    brightness = 3'd7;
  endtask

  task automatic test_leading_zero();
    logic [31:0] v;
    lz_blank = 1'b1;
    v = 32'h0000_0A00;
    value_in = v;
    load_valid = 1'b1;
    step();
    load_valid = 1'b0;
    for (int c = 640; c < 768; c++) begin
      int ph;
      int d;
      run_to(c);
      ph = c % 16;
      d = (c / 16) % 8;
      checks++; if (anodes !== exp_an(ph, d, 14, 8'h07)) begin failures++; $display("[TB] FAIL lz_anodes cyc=%0d got=%h exp=%h", c, anodes, exp_an(ph, d, 14, 8'h07)); end
      checks++; if (nibble !== exp_nib(v, d)) begin failures++; $display("[TB] FAIL lz_nibble cyc=%0d got=%h exp=%h", c, nibble, exp_nib(v, d)); end
    end
    run_to(768);
    value_in = 32'h0000_0000;
    load_valid = 1'b1;
    step();
    load_valid = 1'b0;
    for (int c = 896; c < 1024; c++) begin
      int ph;
      int d;
      run_to(c);
      ph = c % 16;
      d = (c / 16) % 8;
      checks++; if (anodes !== exp_an(ph, d, 14, 8'h01)) begin failures++; $display("[TB] FAIL lz_zero_anodes cyc=%0d got=%h exp=%h", c, anodes, exp_an(ph, d, 14, 8'h01)); end
      checks++; if (nibble !== 4'h0) begin failures++; $display("[TB] FAIL lz_zero_nibble cyc=%0d got=%h exp=0", c, nibble); end
    end
    run_to(1024);
    lz_blank = 1'b0;
  endtask

  task automatic test_load_midframe();
    run_to(1077);
    checks++; if (load_ready !== 1'b1) begin failures++; $display("[TB] FAIL mid_ready_before got=%b exp=1", load_ready); end
    value_in = 32'hAAAA_AAAA;
    load_valid = 1'b1;
    step();
    checks++; if (load_ready !== 1'b0) begin failures++; $display("[TB] FAIL mid_ready_drop got=%b exp=0", load_ready); end
    value_in = 32'h5555_5555;
    step();
    step();
    load_valid = 1'b0;
    for (int c = 1080; c < 1152; c++) begin
      run_to(c);
      checks++; if (nibble !== 4'h0) begin failures++; $display("[TB] FAIL mid_old_nibble cyc=%0d got=%h exp=0", c, nibble); end
      checks++; if (load_ready !== 1'b0) begin failures++; $display("[TB] FAIL mid_ready_pending cyc=%0d got=%b exp=0", c, load_ready); end
    end
    for (int c = 1152; c < 1280; c++) begin
      int ph;
      int d;
      run_to(c);
      ph = c % 16;
      d = (c / 16) % 8;
      checks++; if (nibble !== 4'hA) begin failures++; $display("[TB] FAIL mid_new_nibble cyc=%0d got=%h exp=a", c, nibble); end
      checks++; if (load_ready !== 1'b1) begin failures++; $display("[TB] FAIL mid_ready_after cyc=%0d got=%b exp=1", c, load_ready); end
      checks++; if (anodes !== exp_an(ph, d, 14, 8'hFF)) begin failures++; $display("[TB] FAIL mid_anodes cyc=%0d got=%h exp=%h", c, anodes, exp_an(ph, d, 14, 8'hFF)); end
    end
    run_to(1280);
  endtask

  task automatic test_digit_enable();
    digit_en = 8'b0000_0101;
    for (int c = 1280; c < 1408; c++) begin
      int ph;
      int d;
      run_to(c);
      ph = c % 16;
      d = (c / 16) % 8;
      checks++; if (anodes !== exp_an(ph, d, 14, 8'h05)) begin failures++; $display("[TB] FAIL en_anodes cyc=%0d got=%h exp=%h", c, anodes, exp_an(ph, d, 14, 8'h05)); end
      checks++; if ($countones(~anodes) > 1) begin failures++; $display("[TB] FAIL en_one_low cyc=%0d got=%h exp=at_most_one_low", c, anodes); end
    end
    run_to(1408);
    digit_en = 8'hFF;
  endtask

  task automatic test_reset_midslot();
    run_to(1491);
    value_in = 32'h8765_4321;
    load_valid = 1'b1;
    step();
    load_valid = 1'b0;
    run_to(1493);
    checks++; if (anodes !== 8'hDF) begin failures++; $display("[TB] FAIL rst_pre_anodes got=%h exp=df", anodes); end
    checks++; if (load_ready !== 1'b0) begin failures++; $display("[TB] FAIL rst_pre_ready got=%b exp=0", load_ready); end
    #3;
    reset = 1'b0;
    #1;
    checks++; if (anodes !== 8'hFF) begin failures++; $display("[TB] FAIL rst_async_anodes got=%h exp=ff", anodes); end
    checks++; if (digit_sel !== 3'd0) begin failures++; $display("[TB] FAIL rst_async_digit_sel got=%0d exp=0", digit_sel); end
    checks++; if (load_ready !== 1'b1) begin failures++; $display("[TB] FAIL rst_async_ready got=%b exp=1", load_ready); end
    checks++; if (nibble !== 4'h0) begin failures++; $display("[TB] FAIL rst_async_nibble got=%h exp=0", nibble); end
    @(posedge clock);
    #1;
    checks++; if (digit_sel !== 3'd0 || anodes !== 8'hFF) begin failures++; $display("[TB] FAIL rst_held got=%0d/%h exp=0/ff", digit_sel, anodes); end
    reset = 1'b1;
    cyc = 0;
    for (int c = 0; c < 160; c++) begin
      int ph;
      int d;
      run_to(c);
      ph = c % 16;
      d = (c / 16) % 8;
      checks++; if (anodes !== exp_an(ph, d, 14, 8'hFF)) begin failures++; $display("[TB] FAIL rst_after_anodes cyc=%0d got=%h exp=%h", c, anodes, exp_an(ph, d, 14, 8'hFF)); end
      checks++; if (digit_sel !== 3'(d)) begin failures++; $display("[TB] FAIL rst_after_digit_sel cyc=%0d got=%0d exp=%0d", c, digit_sel, d); end
      checks++; if (nibble !== 4'h0) begin failures++; $display("[TB] FAIL rst_after_nibble cyc=%0d got=%h exp=0", c, nibble); end
    end
  endtask

  // Test sequence: each scenario continues from the cycle where the last ended.
  initial begin
    checks = 0;
    failures = 0;
    cyc = 0;
    reset = 1'b1;
    value_in = 32'h0;
    load_valid = 1'b0;
    digit_en = 8'hFF;
    lz_blank = 1'b0;
    brightness = 3'd7;
    #3;
    reset = 1'b0;
    test_reset();
    do_release();
    test_full_brightness();
    test_brightness();
    test_leading_zero();
    test_load_midframe();
    test_digit_enable();
    test_reset_midslot();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
